// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Decode-stage instruction decoder for a SPARC V8 subset. It turns a 32-bit
//   instruction word into a 19-bit control word. The control word is captured on
//   every rising clock edge, so the decoder has one cycle of latency.
//
// Ports
//   clk            in   1   rising-edge clock
//   clr            in   1   asynchronous active-low reset; clears instr_signals
//   instr          in  32   SPARC V8 instruction word
//   instr_signals  out 19   registered control word:
//                           [18] jmpl  [17] call  [16] branch  [15] load
//                           [14] store [13] rf_le [12] sethi   [11] modify_cc
//                           [10] annul [9:6] alu_op [5:4] size [3] se
//                           [2] mem_en [1] imm    [0] invalid
// -----------------------------------------------------------------------------
module control_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] instr,
   output logic [18:0] instr_signals
);

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_ADDX  = 4'h1,
      ALU_SUB   = 4'h2,
      ALU_SUBX  = 4'h3,
      ALU_AND   = 4'h4,
      ALU_OR    = 4'h5,
      ALU_XOR   = 4'h6,
      ALU_XNOR  = 4'h7,
      ALU_ANDN  = 4'h8,
      ALU_ORN   = 4'h9,
      ALU_SLL   = 4'hA,
      ALU_SRL   = 4'hB,
      ALU_SRA   = 4'hC,
      ALU_PASSB = 4'hD
   } alu_op_e;

   logic [1:0]  op;
   logic [2:0]  op2;
   logic [5:0]  op3;

   logic        jmpl, call, branch, load, store, rf_le, sethi, modify_cc;
   logic        annul, se, mem_en, imm, invalid;
   alu_op_e     alu_op;
   logic [1:0]  size;

   logic [18:0] sig_d, sig_q;

   assign op  = instr[31:30];
   assign op2 = instr[24:22];
   assign op3 = instr[24:19];

   always_comb begin
      jmpl      = 1'b0;
      call      = 1'b0;
      branch    = 1'b0;
      load      = 1'b0;
      store     = 1'b0;
      rf_le     = 1'b0;
      sethi     = 1'b0;
      modify_cc = 1'b0;
      annul     = 1'b0;
      alu_op    = ALU_ADD;
      size      = 2'b00;
      se        = 1'b0;
      imm       = 1'b0;
      invalid   = 1'b0;

      case (op)
         2'b01: begin
            // CALL writes the return address into r15.
            call  = 1'b1;
            rf_le = 1'b1;
         end

         2'b00: begin
            case (op2)
               3'b010: begin
                  branch = 1'b1;
                  annul  = instr[29];
               end
               3'b100: begin
                  // SETHI r0,0 is the canonical NOP and produces an all-zero word.
                  if (instr[29:25] != 5'd0 || instr[21:0] != 22'd0) begin
                     sethi  = 1'b1;
                     rf_le  = 1'b1;
                     alu_op = ALU_PASSB;
                  end
               end
               default: invalid = 1'b1;
            endcase
         end

         2'b10: begin
            rf_le = 1'b1;
            imm   = instr[13];
            // op3[4] selects the cc-setting twin of each basic ALU op.
            casez (op3)
               6'b0?0000: alu_op = ALU_ADD;
               6'b0?0001: alu_op = ALU_AND;
               6'b0?0010: alu_op = ALU_OR;
               6'b0?0011: alu_op = ALU_XOR;
               6'b0?0100: alu_op = ALU_SUB;
               6'b0?0101: alu_op = ALU_ANDN;
               6'b0?0110: alu_op = ALU_ORN;
               6'b0?0111: alu_op = ALU_XNOR;
               6'b0?1000: alu_op = ALU_ADDX;
               6'b0?1100: alu_op = ALU_SUBX;
               6'b100101: alu_op = ALU_SLL;
               6'b100110: alu_op = ALU_SRL;
               6'b100111: alu_op = ALU_SRA;
               6'b111000: jmpl   = 1'b1;
               6'b111100,
               6'b111101: alu_op = ALU_ADD;
               default:   invalid = 1'b1;
            endcase
            modify_cc = ~op3[5] & op3[4];
         end

         default: begin
            imm = instr[13];
            case (op3)
               6'b000000,
               6'b000001,
               6'b000010,
               6'b000011: load = 1'b1;
               6'b001001,
               6'b001010: begin
                  load = 1'b1;
                  se   = 1'b1;
               end
               6'b000100,
               6'b000101,
               6'b000110,
               6'b000111: store = 1'b1;
               default:   invalid = 1'b1;
            endcase
            rf_le = load;
            // op3[1:0] encodes 00 word, 01 byte, 10 half, 11 double; remap to
            // the control word's 00 byte, 01 half, 10 word, 11 double.
            case (op3[1:0])
               2'b01:   size = 2'b00;
               2'b10:   size = 2'b01;
               2'b00:   size = 2'b10;
               default: size = 2'b11;
            endcase
         end
      endcase

      mem_en = load | store;

      // An invalid word carries only the invalid flag. Fields set speculatively
      // above, such as rf_le, imm and size, are discarded here.
      if (invalid) begin
         sig_d = 19'd1;
      end else begin
         sig_d = {jmpl, call, branch, load, store, rf_le, sethi, modify_cc,
                  annul, alu_op, size, se, mem_en, imm, invalid};
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign instr_signals = sig_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. It applies directed instruction words
//   and randomized instruction words. Each captured control word is compared
//   against a table-driven reference model of the instruction set. The bench
//   also exercises reset behaviour, hold without a clock edge, and a reset
//   asserted mid-stream.
// -----------------------------------------------------------------------------
module tb_control_unit;

   logic        clk;
   logic        clr;
   logic [31:0] instr;
   logic [18:0] instr_signals;

   int n_tests;
   int n_fail;

   // Reference tables indexed by op3, one pair for each of op=10 and op=11.
   logic [18:0] tab10 [64];
   bit          ok10  [64];
   logic [18:0] tab11 [64];
   bit          ok11  [64];

   int op3_10 [17] = '{0,1,2,3,4,5,6,7,8,12,37,38,39,56,60,61,16};
   int op3_11 [10] = '{0,1,2,3,9,10,4,5,6,7};

   control_unit dut (
      .clk           (clk),
      .clr           (clr),
      .instr         (instr),
      .instr_signals (instr_signals)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
      end
   endtask

   function automatic void build_tables();
      int alu_op3  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12};
      int alu_code [10] = '{0, 4, 5, 6, 2, 8, 9, 7, 1, 3};
      int ld_op3   [6]  = '{0, 1, 2, 3, 9, 10};
      int ld_size  [6]  = '{2, 0, 1, 3, 0, 1};
      int ld_se    [6]  = '{0, 0, 0, 0, 1, 1};
      int st_op3   [4]  = '{4, 5, 6, 7};
      int st_size  [4]  = '{2, 0, 1, 3};
      for (int i = 0; i < 64; i++) begin
         ok10[i] = 0; ok11[i] = 0; tab10[i] = '0; tab11[i] = '0;
      end
      for (int i = 0; i < 10; i++) begin
         tab10[alu_op3[i]]      = 19'((1 << 13) + alu_code[i] * 64);
         tab10[alu_op3[i] + 16] = 19'((1 << 13) + (1 << 11) + alu_code[i] * 64);
         ok10[alu_op3[i]] = 1; ok10[alu_op3[i] + 16] = 1;
      end
      for (int i = 0; i < 3; i++) begin
         tab10[37 + i] = 19'((1 << 13) + (10 + i) * 64);
         ok10[37 + i] = 1;
      end
      tab10[56] = 19'((1 << 18) + (1 << 13)); ok10[56] = 1;
      tab10[60] = 19'(1 << 13);               ok10[60] = 1;
      tab10[61] = 19'(1 << 13);               ok10[61] = 1;
      for (int i = 0; i < 6; i++) begin
         tab11[ld_op3[i]] = 19'((1 << 15) + (1 << 13) + ld_size[i] * 16 + ld_se[i] * 8 + 4);
         ok11[ld_op3[i]] = 1;
      end
      for (int i = 0; i < 4; i++) begin
         tab11[st_op3[i]] = 19'((1 << 14) + st_size[i] * 16 + 4);
         ok11[st_op3[i]] = 1;
      end
   endfunction

   function automatic logic [18:0] model(input logic [31:0] w);
      int op  = int'(w[31:30]);
      int op2 = int'(w[24:22]);
      int op3 = int'(w[24:19]);
      int v;
      if (op == 1) begin
         v = (1 << 17) + (1 << 13);
      end else if (op == 0) begin
         if (op2 == 2)
            v = (1 << 16) + int'(w[29]) * 1024;
         else if (op2 == 4)
            v = (w[29:25] == 0 && w[21:0] == 0) ? 0 : (1 << 13) + (1 << 12) + 13 * 64;
         else
            v = 1;
      end else if (op == 2) begin
         v = ok10[op3] ? int'(tab10[op3]) + int'(w[13]) * 2 : 1;
      end else begin
         v = ok11[op3] ? int'(tab11[op3]) + int'(w[13]) * 2 : 1;
      end
      return 19'(v);
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int sel = int'($urandom_range(0, 9));
      w[31:30] = 2'($urandom_range(0, 3));
      if (w[31:30] == 2'b10 && sel < 7)
         w[24:19] = 6'(op3_10[$urandom_range(0, 16)]);
      else if (w[31:30] == 2'b11 && sel < 7)
         w[24:19] = 6'(op3_11[$urandom_range(0, 9)]);
      else if (w[31:30] == 2'b00 && sel < 6)
         w[24:22] = (sel < 3) ? 3'b010 : 3'b100;
      else if (w[31:30] == 2'b00 && sel == 6)
         w = 32'h0100_0000;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input string tag, input logic [31:0] w, input logic [18:0] exp);
      instr = w;
      tick();
      check(tag, instr_signals, exp);
   endtask

   initial begin
      logic [31:0] w, w2;
      logic [18:0] held;
      n_tests = 0;
      n_fail  = 0;
      build_tables();

      // The reset holds the output at zero through clock edges.
      clr   = 1'b0;
      instr = 32'h8600_4002;
      #2;
      check("reset_async", instr_signals, 19'h00000);
      repeat (3) tick();
      check("reset_hold", instr_signals, 19'h00000);
      clr = 1'b1;
      tick();
      check("first_capture", instr_signals, 19'h02000);

      // Directed words.
      apply("add",    32'h8600_4002, 19'h02000);
      apply("addcc",  32'h8680_4002, 19'h02800);
      apply("ld",     32'hC400_6004, 19'h0A026);
      apply("ldsb",   32'hC448_6004, 19'h0A00E);
      apply("st",     32'hC420_6004, 19'h04026);
      apply("call",   32'h4000_0004, 19'h22000);
      apply("ba_a",   32'h3080_0002, 19'h10400);
      apply("nop",    32'h0100_0000, 19'h00000);
      apply("unimp",  32'h0000_0000, 19'h00001);
      apply("sethi",  32'h0300_0001, 19'h03340);
      apply("jmpl",   32'h81C3_E008, 19'h42002);
      apply("sll",    32'h8528_6002, 19'h02282);
      apply("ldd",    32'hC418_6004, 19'h0A036);
      apply("bad_op3",32'h8650_0000, 19'h00001);

      // Random back-to-back words. Between edges, a change of instr must not
      // disturb the output.
      for (int i = 0; i < 300; i++) begin
         w = rand_instr();
         instr = w;
         tick();
         held = model(w);
         check("rand", instr_signals, held);
         #2 instr = rand_instr();
         #1 check("hold_no_edge", instr_signals, held);
      end

      // A reset asserted mid-stream clears the output at once and keeps it
      // cleared until the first edge after release.
      for (int i = 0; i < 10; i++) begin
         w = rand_instr();
         instr = w;
         tick();
         check("pre_clr", instr_signals, model(w));
         #2 clr = 1'b0;
         #1 check("clr_immediate", instr_signals, 19'h00000);
         instr = rand_instr();
         tick();
         check("clr_edge_ignored", instr_signals, 19'h00000);
         clr = 1'b1;
         w2 = rand_instr();
         instr = w2;
         tick();
         check("post_clr", instr_signals, model(w2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
